geofence_result_collector: RTL and testbench

- Sits directly downstream of the geofence classifier and consumes its one-cycle valid/is_inside result pulses.
- Tags each result with a sequence number and buffers it in a first-word-fall-through FIFO.
- Drains the FIFO to a host-side ready/valid port.
- Keeps inside/outside statistics and runs a stall watchdog, so lost or late results are visible to the system.

---
 rtl/geofence_result_collector.sv | 127 ++++++++++++
 tb/tb_geofence_result_collector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/geofence_result_collector.sv
// Collects geofence classifier results: sequence tagging, FWFT buffering to a
// ready/valid host port, stall watchdog, and optional statistics (GEOFENCE_STATS_EN).
module geofence_result_collector #(
  parameter int DEPTH   = 8,
  parameter int SEQ_W   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     gf_valid,
  input  logic                     gf_inside,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [SEQ_W-1:0]         out_seq,
  output logic                     out_inside,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         inside_cnt,
  output logic [CNT_W-1:0]         outside_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  output logic                     stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [SEQ_W:0]   mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    level_q;
  logic [SEQ_W-1:0] seq_next;
  logic [WW-1:0]    wd;

  logic full;
  logic pop;
  logic push_ok;
  logic drop;

  assign full    = (level_q == LW'(DEPTH));
  assign pop     = (level_q != '0) && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = gf_valid && (!full || pop);
  assign drop    = gf_valid && full && !pop;

  assign level      = level_q;
  assign out_valid  = (level_q != '0);
  assign out_seq    = out_valid ? mem[rd_ptr][SEQ_W:1] : '0;
  assign out_inside = out_valid ? mem[rd_ptr][0] : 1'b0;

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!clear && push_ok) mem[wr_ptr] <= {seq_next, gf_inside};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level_q  <= '0;
      seq_next <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level_q  <= '0;
      seq_next <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      if (push_ok)  wr_ptr <= wr_ptr + AW'(1);
      if (push_ok && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push_ok) level_q <= level_q - LW'(1);
      if (gf_valid) seq_next <= seq_next + SEQ_W'(1);
      if (drop)     overflow <= 1'b1;
    end
  end

  // Watchdog holds at TIMEOUT; stall is set on the edge the count reaches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd    <= '0;
      stall <= 1'b0;
    end else if (clear) begin
      wd    <= '0;
      stall <= 1'b0;
    end else if (gf_valid) begin
      wd <= '0;
    end else begin
      if (wd != WW'(TIMEOUT))     wd <= wd + WW'(1);
      if (wd >= WW'(TIMEOUT - 1)) stall <= 1'b1;
    end
  end

`ifdef GEOFENCE_STATS_EN
  logic [CNT_W-1:0] inside_q;
  logic [CNT_W-1:0] outside_q;
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inside_q  <= '0;
      outside_q <= '0;
      drop_q    <= '0;
    end else if (clear) begin
      inside_q  <= '0;
      outside_q <= '0;
      drop_q    <= '0;
    end else if (gf_valid) begin
      if (gf_inside && inside_q != '1)   inside_q  <= inside_q + CNT_W'(1);
      if (!gf_inside && outside_q != '1) outside_q <= outside_q + CNT_W'(1);
      if (drop && drop_q != '1)          drop_q    <= drop_q + CNT_W'(1);
    end
  end

  assign inside_cnt  = inside_q;
  assign outside_cnt = outside_q;
  assign drop_cnt    = drop_q;
`else
  assign inside_cnt  = '0;
  assign outside_cnt = '0;
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_geofence_result_collector.sv
// Directed bench for geofence_result_collector: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_geofence_result_collector;

  localparam int DEPTH   = 8;
  localparam int SEQ_W   = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 63;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             gf_valid;
  logic             gf_inside;
  logic             out_ready;
  logic             out_valid;
  logic [SEQ_W-1:0] out_seq;
  logic             out_inside;
  logic [3:0]       level;
  logic [CNT_W-1:0] inside_cnt;
  logic [CNT_W-1:0] outside_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;
  logic             stall;

  int errors = 0;
  int checks = 0;

  geofence_result_collector #(
    .DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .gf_valid(gf_valid), .gf_inside(gf_inside), .out_ready(out_ready),
    .out_valid(out_valid), .out_seq(out_seq), .out_inside(out_inside),
    .level(level), .inside_cnt(inside_cnt), .outside_cnt(outside_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow), .stall(stall)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of {seq, inside} entries
  logic [SEQ_W:0] exp_q[$];
  int m_seq, m_in, m_out, m_drop, m_idle;
  bit m_ovf, m_stall;

  always @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      exp_q.delete();
      m_seq = 0; m_in = 0; m_out = 0; m_drop = 0; m_idle = 0;
      m_ovf = 0; m_stall = 0;
    end else begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (gf_valid) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_seq[SEQ_W-1:0], gf_inside});
        else begin
          m_drop = m_drop + 1;
          m_ovf  = 1;
        end
        if (gf_inside) m_in = m_in + 1;
        else           m_out = m_out + 1;
        m_seq  = (m_seq + 1) % (1 << SEQ_W);
        m_idle = 0;
      end else begin
        if (m_idle < TIMEOUT) m_idle = m_idle + 1;
        if (m_idle == TIMEOUT) m_stall = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs depend only on registered state, sampled on negedge
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
      chk("level", int'(level), exp_q.size());
      chk("out_seq", int'(out_seq), exp_q.size() > 0 ? int'(exp_q[0][SEQ_W:1]) : 0);
      chk("out_inside", int'(out_inside), exp_q.size() > 0 ? int'(exp_q[0][0]) : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("stall", int'(stall), int'(m_stall));
`ifdef GEOFENCE_STATS_EN
      chk("inside_cnt", int'(inside_cnt), m_in);
      chk("outside_cnt", int'(outside_cnt), m_out);
      chk("drop_cnt", int'(drop_cnt), m_drop);
`else
      chk("inside_cnt", int'(inside_cnt), 0);
      chk("outside_cnt", int'(outside_cnt), 0);
      chk("drop_cnt", int'(drop_cnt), 0);
`endif
    end
  end

  // Driver: apply inputs at negedge, return at the following negedge
  task automatic cycle(input logic v, input logic i, input logic r, input logic c);
    gf_valid = v; gf_inside = i; out_ready = r; clear = c;
    @(negedge clk);
  endtask

  int drain_exp[8];

  initial begin
    reset = 1'b1; clear = 1'b0; gf_valid = 1'b0; gf_inside = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    reset = 1'b0;

    // Watchdog expiry at the 63rd idle cycle
    repeat (62) cycle(0, 0, 0, 0);
    chk("wd_before", int'(stall), 0);
    cycle(0, 0, 0, 0);
    chk("wd_expire", int'(stall), 1);

    // Single result, held while out_ready=0
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("single_valid", int'(out_valid), 1);
      chk("single_seq", int'(out_seq), 0);
      chk("single_inside", int'(out_inside), 1);
      chk("single_level", int'(level), 1);
      cycle(0, 0, 0, 0);
    end
    chk("stall_sticky", int'(stall), 1);
    cycle(0, 0, 0, 1);
    chk("clear_stall", int'(stall), 0);
    chk("clear_level", int'(level), 0);

    // Burst of 10 into an 8-deep FIFO
    for (int i = 0; i < 10; i++) cycle(1, i[0], 0, 0);
    chk("burst_level", int'(level), 8);
    chk("burst_ovf", int'(overflow), 1);
`ifdef GEOFENCE_STATS_EN
    chk("burst_drop", int'(drop_cnt), 2);
`endif

    // Push and pop together while full: seq 10 joins the tail
    chk("pp_head", int'(out_seq), 0);
    cycle(1, 1, 1, 0);
    chk("pp_level", int'(level), 8);
`ifdef GEOFENCE_STATS_EN
    chk("pp_drop", int'(drop_cnt), 2);
`endif
    drain_exp = '{1, 2, 3, 4, 5, 6, 7, 10};
    for (int k = 0; k < 8; k++) begin
      chk("drain_seq", int'(out_seq), drain_exp[k]);
      cycle(0, 0, 1, 0);
    end
    chk("drain_level", int'(level), 0);
    cycle(0, 0, 1, 0);
    chk("empty_level", int'(level), 0);

    // Clear wins over a simultaneous result
    repeat (3) cycle(1, 0, 0, 0);
    chk("pre_clear_level", int'(level), 3);
    cycle(1, 1, 0, 1);
    chk("cp_level", int'(level), 0);
    chk("cp_inside", int'(inside_cnt), 0);
    chk("cp_outside", int'(outside_cnt), 0);
    chk("cp_drop", int'(drop_cnt), 0);
    chk("cp_ovf", int'(overflow), 0);
    cycle(1, 1, 0, 0);
    chk("cp_next_seq", int'(out_seq), 0);
    cycle(0, 0, 1, 0);

    // Sequence wrap with 260 alternating results streamed straight through
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 260; i++) begin
      cycle(1, (i % 2 == 0), 1, 0);
      if (i == 255) chk("wrap_255", int'(out_seq), 255);
      if (i == 256) chk("wrap_0", int'(out_seq), 0);
      if (i == 259) chk("wrap_3", int'(out_seq), 3);
    end
    cycle(0, 0, 1, 0);
    chk("wrap_level", int'(level), 0);
`ifdef GEOFENCE_STATS_EN
    chk("wrap_inside", int'(inside_cnt), 130);
    chk("wrap_outside", int'(outside_cnt), 130);
`else
    chk("wrap_inside", int'(inside_cnt), 0);
    chk("wrap_outside", int'(outside_cnt), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
